// File: rtl/valve_actuator.sv
// Valve actuator sequencer: debounces the open request, drives the open/close
// motor until the matching limit switch is reached, and latches travel/sensor faults.
//
// state   | meaning
// --------+-----------------------------------------------------------
// CLOSED  | at closed limit, motors off, dwell timer running
// OPENING | driving toward open, travel timer running
// OPEN    | at open limit, motors off, dwell timer running
// CLOSING | driving toward closed, travel timer running
// FAULT   | travel timeout or limit-switch conflict, waits for fault_clr
module valve_actuator #(
  parameter int DEBOUNCE       = 4,
  parameter int TRAVEL_TIMEOUT = 16,
  parameter int MIN_DWELL      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valve_req,
  input  logic       pos_open,
  input  logic       pos_closed,
  input  logic       fault_clr,
  output logic       motor_open,
  output logic       motor_close,
  output logic [2:0] state,
  output logic       fault
);

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    OPENING = 3'd1,
    OPEN    = 3'd2,
    CLOSING = 3'd3,
    FAULT   = 3'd4
  } state_t;

  localparam logic [3:0] DB_LAST   = 4'(DEBOUNCE - 1);
  localparam logic [7:0] TRAV_LAST = 8'(TRAVEL_TIMEOUT - 1);
  localparam logic [7:0] DWELL_MAX = 8'(MIN_DWELL);

  state_t     state_q;
  state_t     state_nxt;
  logic       req_filt;
  logic [3:0] db_cnt;
  logic [7:0] dwell_cnt;
  logic [7:0] trav_cnt;
  logic       dwell_done;
  logic       conflict;

  assign dwell_done = (dwell_cnt == DWELL_MAX);
  assign conflict   = pos_open & pos_closed;
  assign state      = state_q;
  assign fault      = (state_q == FAULT);

  // Request filter: a new level must persist DEBOUNCE edges before acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_filt <= 1'b0;
      db_cnt   <= 4'd0;
    end else if (valve_req != req_filt) begin
      if (db_cnt == DB_LAST) begin
        req_filt <= valve_req;
        db_cnt   <= 4'd0;
      end else begin
        db_cnt <= db_cnt + 4'd1;
      end
    end else begin
      db_cnt <= 4'd0;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      CLOSED: begin
        if (req_filt && dwell_done) state_nxt = OPENING;
      end
      OPENING: begin
        if (pos_open)                   state_nxt = OPEN;
        else if (!req_filt)             state_nxt = CLOSING;
        else if (trav_cnt == TRAV_LAST) state_nxt = FAULT;
      end
      OPEN: begin
        if (!req_filt && dwell_done) state_nxt = CLOSING;
      end
      CLOSING: begin
        if (pos_closed)                 state_nxt = CLOSED;
        else if (req_filt)              state_nxt = OPENING;
        else if (trav_cnt == TRAV_LAST) state_nxt = FAULT;
      end
      FAULT: begin
        if (fault_clr && !conflict) state_nxt = pos_closed ? CLOSED : CLOSING;
      end
      default: state_nxt = CLOSED;
    endcase
    // Both limits at once means a broken sensor; this overrides everything
    if (state_q != FAULT && conflict) state_nxt = FAULT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLOSED;
      motor_open  <= 1'b0;
      motor_close <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      motor_open  <= (state_nxt == OPENING);
      motor_close <= (state_nxt == CLOSING);
    end
  end

  // Any state change restarts both timers, including a direct reversal
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt <= 8'd0;
      trav_cnt  <= 8'd0;
    end else if (state_nxt != state_q) begin
      dwell_cnt <= 8'd0;
      trav_cnt  <= 8'd0;
    end else begin
      case (state_q)
        CLOSED, OPEN: begin
          if (!dwell_done) dwell_cnt <= dwell_cnt + 8'd1;
        end
        OPENING, CLOSING: begin
          if (trav_cnt != TRAV_LAST) trav_cnt <= trav_cnt + 8'd1;
        end
        default: begin
          dwell_cnt <= 8'd0;
          trav_cnt  <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/valve_actuator.md
VALVE_ACTUATOR -- requirements
Module: valve_actuator

Interface
REQ-001 The block SHALL have parameter DEBOUNCE, default 4, meaning consecutive cycles valve_req must hold a new level before acceptance (legal range 2..15).
REQ-002 The block SHALL have parameter TRAVEL_TIMEOUT, default 16, meaning maximum cycles in OPENING or CLOSING before a fault (legal range 2..255).
REQ-003 The block SHALL have parameter MIN_DWELL, default 8, meaning minimum cycles spent in CLOSED or OPEN before a new move starts (legal range 1..255).
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 Port: clk  input  1  rising-edge system clock.
REQ-006 Port: rst_n  input  1  asynchronous active-low reset.
REQ-007 Port: valve_req  input  1  open command from the flowcontrol decision logic; 1 = open, 0 = closed.
REQ-008 Port: pos_open  input  1  fully-open limit switch, active high.
REQ-009 Port: pos_closed  input  1  fully-closed limit switch, active high.
REQ-010 Port: fault_clr  input  1  single-cycle fault acknowledge pulse.
REQ-011 Port: motor_open  output  1  drive the actuator toward open.
REQ-012 Port: motor_close  output  1  drive the actuator toward closed.
REQ-013 Port: state  output  3  current state: CLOSED=0, OPENING=1, OPEN=2, CLOSING=3, FAULT=4.
REQ-014 Port: fault  output  1  high exactly when state = FAULT.

Function
REQ-015 Internal req_filt (reset 0) SHALL take the value of valve_req on the DEBOUNCE-th consecutive rising edge at which valve_req != req_filt; any edge with equality clears the debounce count.
REQ-016 motor_open SHALL be 1 only in OPENING; motor_close SHALL be 1 only in CLOSING; both outputs SHALL be registered and never high together.
REQ-017 The dwell counter SHALL clear on entry to CLOSED or OPEN, increment each cycle there, and saturate at MIN_DWELL; dwell_done = (count == MIN_DWELL).
REQ-018 The travel counter SHALL clear on entry to OPENING or CLOSING and increment each cycle there.
REQ-019 CLOSED: if req_filt=1 and dwell_done, the next state SHALL be OPENING; otherwise the state holds.
REQ-020 OPENING: if pos_open=1, the next state SHALL be OPEN; else if req_filt=0, CLOSING (immediate reversal, travel counter cleared); else if travel count = TRAVEL_TIMEOUT-1, FAULT.
REQ-021 OPEN: if req_filt=0 and dwell_done, the next state SHALL be CLOSING.
REQ-022 CLOSING: mirror of REQ-020 with pos_closed, req_filt=1 leading to OPENING, and destination CLOSED.
REQ-023 In any non-FAULT state, pos_open=1 and pos_closed=1 in the same cycle SHALL force FAULT at the next edge, with priority over every other transition.
REQ-024 FAULT: the state SHALL hold with both motors off until fault_clr=1; it then goes to CLOSED if pos_closed=1, otherwise to CLOSING. fault_clr is ignored outside FAULT and while both limit switches are high.
REQ-025 Limit-switch arrival SHALL take priority over timeout in the same cycle.
REQ-026 Changes of valve_req shorter than DEBOUNCE cycles SHALL have no effect on any output.

Reset
REQ-027 While rst_n=0, the block SHALL asynchronously set state=CLOSED, motor_open=0, motor_close=0, fault=0, req_filt=0, and all counters to 0; reset mid-travel SHALL stop the motor immediately.
REQ-028 After rst_n deasserts, the first transition out of CLOSED SHALL wait at least MIN_DWELL cycles.

Verification (defaults DEBOUNCE=4, TRAVEL_TIMEOUT=16, MIN_DWELL=8)
REQ-029 Open path: reset with pos_closed=1, hold 10 cycles, then valve_req=1 -> req_filt=1 after the 4th edge, motor_open=1 on the next edge, state=1; assert pos_open 5 cycles later -> state=2, motor_open=0 one edge later.
REQ-030 Glitch: valve_req high for 3 cycles, then low -> state stays 0 and motor_open stays 0 throughout.
REQ-031 Timeout: in OPENING, hold pos_open=0 -> state=4, fault=1 on the 16th edge after entry; then a fault_clr pulse with pos_closed=0 -> state=3, motor_close=1.
REQ-032 Reversal: in OPENING at travel count 6, drop valve_req for 4 cycles -> state=3 at the next edge, motor_open=0, motor_close=1, never both high.
REQ-033 Sensor conflict: in OPEN, drive pos_open=pos_closed=1 -> state=4 next edge; a fault_clr pulse while both are high -> state stays 4.
REQ-034 Async reset: assert rst_n=0 mid-CLOSING between clock edges -> motor_close=0 and state=0 immediately, without waiting for a clock edge.
